// File: rtl/io_mem_sched.sv
// Turns SPI toggle strobes into SDRAM word transactions: write FIFO, DMA pointer, read prefetch.
// Only one transaction is outstanding at a time, and a pending read always wins the next slot.
module io_mem_sched #(
    parameter int ADDR_WIDTH = 23,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mist_wr_strobe,
    input  logic                  uio_wr_strobe,
    input  logic                  rd_strobe,
    input  logic [15:0]           data_in,
    input  logic [ADDR_WIDTH-1:0] uio_addr,
    input  logic                  dma_addr_load,
    input  logic [ADDR_WIDTH-1:0] dma_addr_in,
    output logic [15:0]           data_out,
    input  logic                  mem_slot,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [15:0]           mem_din,
    input  logic                  mem_ack,
    input  logic [15:0]           mem_dout,
    output logic [ADDR_WIDTH-1:0] dma_ptr,
    output logic                  overrun,
    output logic                  busy
);
    localparam int PW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

    state_t                state_q, state_d;
    logic                  mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d, dma_ptr_q, dma_ptr_d;
    logic [15:0]           mem_din_q, mem_din_d, data_out_q, data_out_d;
    logic                  overrun_q, overrun_d, rd_pend_q, rd_pend_d, discard_q, discard_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]           count_q, count_d;
    logic                  defer_vld_q, defer_vld_d;
    logic [ADDR_WIDTH-1:0] defer_addr_q, defer_addr_d;
    logic [15:0]           defer_data_q, defer_data_d;
    logic                  mist_strobe_q, uio_strobe_q, rd_strobe_q;
    logic [ADDR_WIDTH-1:0] fifo_addr [FIFO_DEPTH];
    logic [15:0]           fifo_data [FIFO_DEPTH];

    logic                  mist_ev, uio_ev, rd_ev, rd_ev_ok;
    logic                  push_vld, push_ok, push_drop, drop_extra, pop;
    logic [ADDR_WIDTH-1:0] push_addr;
    logic [15:0]           push_data;
    logic                  rd_keep, start_rd, start_wr;

    assign mist_ev  = mist_wr_strobe ^ mist_strobe_q;
    assign uio_ev   = uio_wr_strobe ^ uio_strobe_q;
    assign rd_ev    = rd_strobe ^ rd_strobe_q;
    assign rd_ev_ok = rd_ev && !rd_pend_q && (state_q != READ);
    assign pop      = (state_q == WRITE) && mem_ack;
    assign push_ok  = push_vld && ((count_q != (PW+1)'(FIFO_DEPTH)) || pop);
    assign push_drop = push_vld && !push_ok;
    // A read whose pointer was reloaded mid-flight still handshakes but is thrown away.
    assign rd_keep  = (state_q == READ) && mem_ack && !discard_q && !dma_addr_load;
    assign start_rd = (state_q == IDLE) && mem_slot && rd_pend_q && !dma_addr_load;
    assign start_wr = (state_q == IDLE) && mem_slot && !rd_pend_q && (count_q != '0);

    // Push arbitration: a deferred UIO word goes first, then MIST, then UIO; the loser is deferred.
    always_comb begin
        push_vld     = 1'b0;
        push_addr    = '0;
        push_data    = '0;
        drop_extra   = 1'b0;
        defer_vld_d  = 1'b0;
        defer_addr_d = defer_addr_q;
        defer_data_d = defer_data_q;
        if (defer_vld_q) begin
            push_vld  = 1'b1;
            push_addr = defer_addr_q;
            push_data = defer_data_q;
            if (mist_ev) begin
                defer_vld_d  = 1'b1;
                defer_addr_d = dma_ptr_q;
                defer_data_d = data_in;
                drop_extra   = uio_ev;
            end else if (uio_ev) begin
                defer_vld_d  = 1'b1;
                defer_addr_d = uio_addr;
                defer_data_d = data_in;
            end
        end else if (mist_ev) begin
            push_vld  = 1'b1;
            push_addr = dma_ptr_q;
            push_data = data_in;
            if (uio_ev) begin
                defer_vld_d  = 1'b1;
                defer_addr_d = uio_addr;
                defer_data_d = data_in;
            end
        end else if (uio_ev) begin
            push_vld  = 1'b1;
            push_addr = uio_addr;
            push_data = data_in;
        end
    end

    always_comb begin
        wr_ptr_d   = push_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d    = count_q + (PW+1)'(push_ok) - (PW+1)'(pop);
        rd_pend_d  = (rd_pend_q && !start_rd) || dma_addr_load || rd_ev_ok;
        discard_d  = discard_q;
        if ((state_q == READ) && mem_ack)
            discard_d = 1'b0;
        else if ((state_q == READ) && dma_addr_load)
            discard_d = 1'b1;
        dma_ptr_d  = dma_addr_load ? dma_addr_in
                   : dma_ptr_q + ADDR_WIDTH'(mist_ev) + ADDR_WIDTH'(rd_keep);
        data_out_d = rd_keep ? mem_dout : data_out_q;
        overrun_d  = (overrun_q && !dma_addr_load) || push_drop || drop_extra || (rd_ev && !rd_ev_ok);
    end

    always_comb begin
        state_d    = state_q;
        mem_req_d  = mem_req_q;
        mem_we_d   = mem_we_q;
        mem_addr_d = mem_addr_q;
        mem_din_d  = mem_din_q;
        case (state_q)
            IDLE: begin
                if (start_rd) begin
                    state_d    = READ;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = dma_ptr_q;
                end else if (start_wr) begin
                    state_d    = WRITE;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b1;
                    mem_addr_d = fifo_addr[rd_ptr_q];
                    mem_din_d  = fifo_data[rd_ptr_q];
                end
            end
            WRITE, READ: begin
                if (mem_ack) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_din_q   <= '0;
            dma_ptr_q   <= '0;
            data_out_q  <= '0;
            overrun_q   <= 1'b0;
            rd_pend_q   <= 1'b0;
            discard_q   <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            defer_vld_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_din_q   <= mem_din_d;
            dma_ptr_q   <= dma_ptr_d;
            data_out_q  <= data_out_d;
            overrun_q   <= overrun_d;
            rd_pend_q   <= rd_pend_d;
            discard_q   <= discard_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            defer_vld_q <= defer_vld_d;
        end
    end

    // Strobe copies track their inputs through reset, so no event fires on release.
    always_ff @(posedge clk) begin
        mist_strobe_q <= mist_wr_strobe;
        uio_strobe_q  <= uio_wr_strobe;
        rd_strobe_q   <= rd_strobe;
        defer_addr_q  <= defer_addr_d;
        defer_data_q  <= defer_data_d;
        if (push_ok) begin
            fifo_addr[wr_ptr_q] <= push_addr;
            fifo_data[wr_ptr_q] <= push_data;
        end
    end

    assign mem_req  = mem_req_q;
    assign mem_we   = mem_we_q;
    assign mem_addr = mem_addr_q;
    assign mem_din  = mem_din_q;
    assign dma_ptr  = dma_ptr_q;
    assign data_out = data_out_q;
    assign overrun  = overrun_q;
    assign busy     = (count_q != '0) || defer_vld_q || rd_pend_q || mem_req_q;
endmodule

// File: tb/tb_io_mem_sched.sv
// Bench for io_mem_sched: SDRAM responder with random latency plus a word-level memory/pointer model.
module tb_io_mem_sched;
    localparam int AW = 23;

    logic          clk, reset, mist_wr_strobe, uio_wr_strobe, rd_strobe;
    logic [15:0]   data_in;
    logic [AW-1:0] uio_addr, dma_addr_in;
    logic          dma_addr_load;
    logic [15:0]   data_out;
    logic          mem_slot, mem_req, mem_we, mem_ack;
    logic [AW-1:0] mem_addr, dma_ptr;
    logic [15:0]   mem_din, mem_dout;
    logic          overrun, busy;

    typedef struct packed { logic we; logic [AW-1:0] addr; logic [15:0] data; } txn_t;
    txn_t        txq[$];
    txn_t        exq[$];
    logic [15:0] mem [int];
    logic [15:0] ref_mem [int];
    int n_checks = 0, n_fail = 0, stab_err = 0, gap_err = 0;
    int lat_lo = 0, lat_hi = 3;
    bit slot_rand = 0, slot_force = 0, in_txn = 0, just_acked = 0;
    int cnt = 0;
    txn_t cur;

    io_mem_sched #(.ADDR_WIDTH(AW), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .mist_wr_strobe(mist_wr_strobe), .uio_wr_strobe(uio_wr_strobe),
        .rd_strobe(rd_strobe), .data_in(data_in), .uio_addr(uio_addr), .dma_addr_load(dma_addr_load),
        .dma_addr_in(dma_addr_in), .data_out(data_out), .mem_slot(mem_slot), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_ack(mem_ack),
        .mem_dout(mem_dout), .dma_ptr(dma_ptr), .overrun(overrun), .busy(busy)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

    function automatic logic [15:0] dflt(input logic [AW-1:0] a);
        logic [AW-1:0] t;
        t = a;
        return t[15:0] ^ {9'h0, t[22:16]} ^ 16'h5A3C;
    endfunction

    function automatic logic [15:0] exp_rd(input logic [AW-1:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : dflt(a);
    endfunction

    initial begin
        mem_slot = 0;
        forever begin
            @(negedge clk);
            mem_slot = slot_rand ? ($urandom_range(0, 3) != 0) : slot_force;
        end
    end

    // SDRAM model: logs each request, holds it for a random latency, then acks for one cycle.
    initial begin
        mem_ack = 0;
        mem_dout = 0;
        forever begin
            @(negedge clk);
            mem_ack = 0;
            if (reset) begin
                in_txn = 0;
                just_acked = 0;
            end else begin
                if (just_acked && mem_req) gap_err++;
                just_acked = 0;
                if (in_txn) begin
                    if (!mem_req || mem_we !== cur.we || mem_addr !== cur.addr ||
                        (cur.we && mem_din !== cur.data)) stab_err++;
                end else if (mem_req) begin
                    cur.we = mem_we;
                    cur.addr = mem_addr;
                    cur.data = mem_we ? mem_din : 16'h0;
                    txq.push_back(cur);
                    in_txn = 1;
                    cnt = $urandom_range(lat_hi, lat_lo);
                end
                if (in_txn) begin
                    if (cnt == 0) begin
                        mem_ack = 1;
                        if (cur.we) mem[int'(cur.addr)] = cur.data;
                        else mem_dout = mem.exists(int'(cur.addr)) ? mem[int'(cur.addr)] : dflt(cur.addr);
                        in_txn = 0;
                        just_acked = 1;
                    end else begin
                        cnt--;
                    end
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_load(input logic [AW-1:0] a);
        @(negedge clk);
        dma_addr_in = a;
        dma_addr_load = 1;
        @(negedge clk);
        dma_addr_load = 0;
    endtask

    task automatic tog_mist(input logic [15:0] d);
        @(negedge clk);
        data_in = d;
        mist_wr_strobe = ~mist_wr_strobe;
    endtask

    task automatic wait_idle(input string tag);
        int quiet = 0;
        int k = 0;
        while (quiet < 3 && k < 500) begin
            @(negedge clk);
            k++;
            if (!busy && !mem_req && !in_txn) quiet++;
            else quiet = 0;
        end
        n_checks++;
        if (quiet < 3) begin
            n_fail++;
            $display("FAIL %s_idle: busy=%0b mem_req=%0b after %0d cycles, required idle", tag, busy, mem_req, k);
        end
    endtask

    task automatic test_reset;
        logic [AW*2+35:0] got;
        got = {data_out, mem_req, mem_we, mem_addr, mem_din, dma_ptr, overrun, busy};
        n_checks++;
        if (got !== '0) begin
            n_fail++;
            $display("FAIL reset_values: got %h, required 0", got);
        end
        slot_force = 1;
        txq.delete();
        cyc(10);
        n_checks++;
        if (txq.size() != 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_quiet: got %0d transactions busy=%0b, required 0 and 0", txq.size(), busy);
        end
    endtask

    task automatic test_read_prefetch;
        mem[32'h100] = 16'hBEEF; ref_mem[32'h100] = 16'hBEEF;
        mem[32'h101] = 16'h1234; ref_mem[32'h101] = 16'h1234;
        txq.delete();
        do_load(23'h000100);
        wait_idle("prefetch");
        n_checks++;
        if (data_out !== 16'hBEEF || dma_ptr !== 23'h101) begin
            n_fail++;
            $display("FAIL prefetch_data: got data_out=%h dma_ptr=%h, required BEEF 000101", data_out, dma_ptr);
        end
        @(negedge clk); rd_strobe = ~rd_strobe;
        wait_idle("next_read");
        n_checks++;
        if (data_out !== 16'h1234 || dma_ptr !== 23'h102) begin
            n_fail++;
            $display("FAIL next_read_data: got data_out=%h dma_ptr=%h, required 1234 000102", data_out, dma_ptr);
        end
        exq = '{'{1'b0, 23'h100, 16'h0}, '{1'b0, 23'h101, 16'h0}};
        n_checks++;
        if (txq != exq) begin
            n_fail++;
            $display("FAIL read_txns: got %0d txns first addr=%h, required 2 reads at 100,101",
                     txq.size(), txq.size() > 0 ? txq[0].addr : 23'h0);
        end
    endtask

    task automatic test_fifo_overrun;
        slot_force = 0;
        cyc(2);
        txq.delete();
        do_load(23'h000010);
        for (int i = 1; i <= 4; i++) tog_mist(16'(i));
        cyc(2);
        n_checks++;
        if (mem_req !== 1'b0 || busy !== 1'b1 || overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL fifo_full_state: got mem_req=%0b busy=%0b overrun=%0b, required 0 1 0", mem_req, busy, overrun);
        end
        tog_mist(16'h0005);
        cyc(2);
        n_checks++;
        if (overrun !== 1'b1 || dma_ptr !== 23'h15) begin
            n_fail++;
            $display("FAIL fifo_overrun: got overrun=%0b dma_ptr=%h, required 1 000015", overrun, dma_ptr);
        end
        exq.delete();
        exq.push_back('{1'b0, 23'h15, 16'h0});
        for (int i = 0; i < 4; i++) begin
            exq.push_back('{1'b1, 23'h10 + 23'(i), 16'(i + 1)});
            ref_mem[32'h10 + i] = 16'(i + 1);
        end
        slot_force = 1;
        wait_idle("fifo_drain");
        n_checks++;
        if (txq.size() != exq.size()) begin
            n_fail++;
            $display("FAIL fifo_txn_count: got %0d, required %0d", txq.size(), exq.size());
        end else begin
            foreach (exq[i]) begin
                n_checks++;
                if (txq[i] !== exq[i]) begin
                    n_fail++;
                    $display("FAIL fifo_txn%0d: got we=%0b addr=%h data=%h, required we=%0b addr=%h data=%h",
                             i, txq[i].we, txq[i].addr, txq[i].data, exq[i].we, exq[i].addr, exq[i].data);
                end
            end
        end
        n_checks++;
        if (dma_ptr !== 23'h16 || data_out !== exp_rd(23'h15) || overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL fifo_after: got dma_ptr=%h data_out=%h overrun=%0b, required 000016 %h 1",
                     dma_ptr, data_out, overrun, exp_rd(23'h15));
        end
    endtask

    task automatic test_simultaneous;
        do_load(23'h00001F);
        wait_idle("simul_load");
        txq.delete();
        @(negedge clk);
        data_in = 16'hCAFE;
        uio_addr = 23'h7F0000;
        mist_wr_strobe = ~mist_wr_strobe;
        uio_wr_strobe = ~uio_wr_strobe;
        wait_idle("simul");
        ref_mem[32'h20] = 16'hCAFE;
        ref_mem[32'h7F0000] = 16'hCAFE;
        exq = '{'{1'b1, 23'h20, 16'hCAFE}, '{1'b1, 23'h7F0000, 16'hCAFE}};
        n_checks++;
        if (txq != exq) begin
            n_fail++;
            $display("FAIL simul_order: got %0d txns first=%h second=%h, required writes at 000020 then 7f0000",
                     txq.size(), txq.size() > 0 ? txq[0].addr : 23'h0, txq.size() > 1 ? txq[1].addr : 23'h0);
        end
        n_checks++;
        if (dma_ptr !== 23'h21 || overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL simul_ptr: got dma_ptr=%h overrun=%0b, required 000021 0", dma_ptr, overrun);
        end
    endtask

    task automatic test_wrap;
        do_load(23'h7FFFFE);
        wait_idle("wrap_load");
        n_checks++;
        if (dma_ptr !== 23'h7FFFFF || data_out !== exp_rd(23'h7FFFFE)) begin
            n_fail++;
            $display("FAIL wrap_load: got dma_ptr=%h data_out=%h, required 7fffff %h", dma_ptr, data_out, exp_rd(23'h7FFFFE));
        end
        txq.delete();
        @(negedge clk); rd_strobe = ~rd_strobe;
        wait_idle("wrap");
        n_checks++;
        if (dma_ptr !== 23'h0 || data_out !== exp_rd(23'h7FFFFF) || txq.size() != 1 ||
            txq[0] !== txn_t'{1'b0, 23'h7FFFFF, 16'h0}) begin
            n_fail++;
            $display("FAIL wrap_read: got dma_ptr=%h data_out=%h txns=%0d, required 000000 %h 1 read at 7fffff",
                     dma_ptr, data_out, txq.size(), exp_rd(23'h7FFFFF));
        end
    endtask

    task automatic test_priority;
        slot_force = 0;
        lat_lo = 5; lat_hi = 5;
        stab_err = 0; gap_err = 0;
        cyc(2);
        txq.delete();
        @(negedge clk);
        data_in = 16'h5555;
        mist_wr_strobe = ~mist_wr_strobe;
        rd_strobe = ~rd_strobe;
        cyc(3);
        slot_force = 1;
        wait_idle("priority");
        ref_mem[32'h0] = 16'h5555;
        exq = '{'{1'b0, 23'h1, 16'h0}, '{1'b1, 23'h0, 16'h5555}};
        n_checks++;
        if (txq != exq) begin
            n_fail++;
            $display("FAIL priority_order: got %0d txns first we=%0b, required read at 000001 then write at 000000",
                     txq.size(), txq.size() > 0 ? txq[0].we : 1'b1);
        end
        n_checks++;
        if (stab_err != 0 || gap_err != 0) begin
            n_fail++;
            $display("FAIL priority_handshake: got stability errors=%0d gap errors=%0d, required 0 0", stab_err, gap_err);
        end
        n_checks++;
        if (dma_ptr !== 23'h2 || data_out !== exp_rd(23'h1)) begin
            n_fail++;
            $display("FAIL priority_data: got dma_ptr=%h data_out=%h, required 000002 %h", dma_ptr, data_out, exp_rd(23'h1));
        end
        lat_lo = 0; lat_hi = 3;
    endtask

    task automatic test_random;
        logic [AW-1:0] a, p, u;
        logic [15:0]   d;
        slot_rand = 1;
        stab_err = 0; gap_err = 0;
        for (int r = 0; r < 6; r++) begin
            a = AW'($urandom);
            do_load(a);
            wait_idle("rand_load");
            p = a + AW'(1);
            n_checks++;
            if (data_out !== exp_rd(a) || dma_ptr !== p) begin
                n_fail++;
                $display("FAIL rand_load%0d: got data_out=%h dma_ptr=%h, required %h %h", r, data_out, dma_ptr, exp_rd(a), p);
            end
            txq.delete();
            exq.delete();
            for (int n = $urandom_range(1, 4); n > 0; n--) begin
                d = 16'($urandom);
                @(negedge clk);
                data_in = d;
                if ($urandom_range(0, 1) == 0) begin
                    mist_wr_strobe = ~mist_wr_strobe;
                    exq.push_back('{1'b1, p, d});
                    ref_mem[int'(p)] = d;
                    p = p + AW'(1);
                end else begin
                    u = AW'($urandom);
                    uio_addr = u;
                    uio_wr_strobe = ~uio_wr_strobe;
                    exq.push_back('{1'b1, u, d});
                    ref_mem[int'(u)] = d;
                end
                cyc($urandom_range(1, 3));
            end
            wait_idle("rand_wr");
            n_checks++;
            if (txq != exq || dma_ptr !== p) begin
                n_fail++;
                $display("FAIL rand_writes%0d: got %0d txns dma_ptr=%h, required %0d txns dma_ptr=%h",
                         r, txq.size(), dma_ptr, exq.size(), p);
            end
            for (int j = 0; j < 2; j++) begin
                @(negedge clk); rd_strobe = ~rd_strobe;
                wait_idle("rand_rd");
                n_checks++;
                if (data_out !== exp_rd(p) || dma_ptr !== p + AW'(1)) begin
                    n_fail++;
                    $display("FAIL rand_read%0d_%0d: got data_out=%h dma_ptr=%h, required %h %h",
                             r, j, data_out, dma_ptr, exp_rd(p), p + AW'(1));
                end
                p = p + AW'(1);
            end
        end
        slot_rand = 0;
        slot_force = 1;
        n_checks++;
        if (stab_err != 0 || gap_err != 0 || overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL rand_handshake: got stability=%0d gap=%0d overrun=%0b, required 0 0 0", stab_err, gap_err, overrun);
        end
    endtask

    task automatic test_reset_midflight;
        logic [AW*2+35:0] got;
        int k = 0;
        lat_lo = 20; lat_hi = 20;
        slot_force = 1;
        do_load(23'h000300);
        while (!mem_req && k < 30) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (mem_req !== 1'b1) begin
            n_fail++;
            $display("FAIL midflight_req: got mem_req=%0b after %0d cycles, required 1", mem_req, k);
        end
        @(negedge clk);
        #2 reset = 1;
        #1 got = {data_out, mem_req, mem_we, mem_addr, mem_din, dma_ptr, overrun, busy};
        n_checks++;
        if (got !== '0) begin
            n_fail++;
            $display("FAIL midflight_reset: got %h, required 0", got);
        end
        cyc(3);
        reset = 0;
        txq.delete();
        lat_lo = 0; lat_hi = 3;
        cyc(12);
        n_checks++;
        if (txq.size() != 0 || mem_req !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midflight_quiet: got %0d txns mem_req=%0b busy=%0b, required 0 0 0", txq.size(), mem_req, busy);
        end
    endtask

    initial begin
        reset = 1;
        mist_wr_strobe = 0;
        uio_wr_strobe = 0;
        rd_strobe = 0;
        data_in = 0;
        uio_addr = 0;
        dma_addr_load = 0;
        dma_addr_in = 0;
        cyc(4);
        reset = 0;
        cyc(1);
        test_reset();
        test_read_prefetch();
        test_fifo_overrun();
        test_simultaneous();
        test_wrap();
        test_priority();
        test_random();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/io_mem_sched.md
Name: io_mem_sched

Overview:
- Schedules the SPI data interface's word traffic onto the shared SDRAM port. It turns the toggle-style strobes (MIST write, UIO file-download write, MIST read) into memory transactions.
- Keeps the MIST DMA word pointer. Buffers write words in a small FIFO. Prefetches read words so the SPI transmitter always has the next word ready.
- Issues requests only in the memory slots that the CPU/video timing grants to it.

Parameters:
- ADDR_WIDTH, 23, word address width (address bits [23:1]).
- FIFO_DEPTH, 4, write FIFO entries; power of two, 2..16.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- mist_wr_strobe  in  1  toggle; a change means data_in holds a new MIST write word.
- uio_wr_strobe  in  1  toggle; a change means data_in and uio_addr hold a new download word.
- rd_strobe  in  1  toggle; a change means the current data_out was consumed.
- data_in  in  16  write data word.
- uio_addr  in  ADDR_WIDTH  word address for the UIO write.
- dma_addr_load  in  1  one-cycle pulse that loads the DMA pointer.
- dma_addr_in  in  ADDR_WIDTH  new DMA word pointer.
- data_out  out  16  prefetched read word, fed to the SPI transmitter.
- mem_slot  in  1  high when this block may start a memory transaction this cycle.
- mem_req  out  1  request; held until mem_ack.
- mem_we  out  1  1 = write, 0 = read; valid while mem_req is high.
- mem_addr  out  ADDR_WIDTH  transaction word address.
- mem_din  out  16  write data.
- mem_ack  in  1  one-cycle completion pulse; mem_dout is valid in the same cycle.
- mem_dout  in  16  read data.
- dma_ptr  out  ADDR_WIDTH  current DMA pointer, for status readback.
- overrun  out  1  sticky error flag.
- busy  out  1  high when the FIFO is non-empty, a read is pending, or mem_req is high.

Behaviour:
- Reset values: data_out=0, mem_req=0, mem_we=0, mem_addr=0, mem_din=0, dma_ptr=0, overrun=0, busy=0. FIFO empty, no read pending. Edge-detect registers are loaded from their strobe inputs so no spurious event fires after reset.
- Event detection: each toggle input is registered once; a change from the registered copy is a one-cycle event. Inputs are already in the clk domain. An event is acted on one cycle after the toggle edge.
- MIST write event: push {dma_ptr, data_in}; dma_ptr <= dma_ptr+1.
- UIO write event: push {uio_addr, data_in}. dma_ptr is unchanged.
- Simultaneous MIST and UIO events: MIST is pushed that cycle. The UIO entry is captured into a one-deep defer register and pushed the next cycle, ahead of any new event.
- FIFO: single push per cycle, single pop per cycle, push and pop allowed in the same cycle. Push while full: the entry is dropped and overrun is set; a MIST push still advances dma_ptr.
- dma_addr_load: dma_ptr <= dma_addr_in and a read is marked pending (prefetch); overrun is cleared. Write entries already in the FIFO are kept.
- rd_strobe event: a read is marked pending. If a read is already pending or in flight, overrun is set and no extra read is queued.
- Read address: a read fetches the word at dma_ptr. On its mem_ack, data_out <= mem_dout and dma_ptr <= dma_ptr+1.
  - Net effect: after load to A, data_out = mem[A] and dma_ptr = A+1.
  - Each consumed word triggers the fetch of the next one.
- Pointer arithmetic: dma_ptr increments modulo 2^ADDR_WIDTH; all-ones wraps to 0.
- Scheduler FSM, states IDLE, WRITE, READ:
  - IDLE and mem_slot=1: read pending -> READ. Else FIFO non-empty -> WRITE. Else stay in IDLE.
  - Entering READ: mem_req=1, mem_we=0, mem_addr=dma_ptr, and the pending flag clears.
  - Entering WRITE: mem_req=1, mem_we=1, {mem_addr, mem_din} = FIFO head. The pop happens on mem_ack.
  - In WRITE or READ: mem_req and all mem_* outputs stay stable until mem_ack. Then mem_req=0 in the next cycle and the state returns to IDLE. At most one transaction is outstanding.
  - Minimum gap: one IDLE cycle between transactions.
- dma_addr_load while a READ is in flight: that read's mem_ack completes the bus handshake, but its data and its pointer increment are discarded. The new prefetch then runs.
- Read priority over writes is intentional: it keeps the SPI read path within the byte time.

Test Plan:
- Load 0x000100, model memory with mem[0x100]=0xBEEF and mem[0x101]=0x1234, mem_slot=1 -> one read at 0x100; data_out=0xBEEF, dma_ptr=0x101. Toggle rd_strobe -> read at 0x101; data_out=0x1234, dma_ptr=0x102.
- Load 0x000010, then four MIST write toggles with data 0x0001..0x0004, mem_slot=0 -> FIFO full, no mem_req, busy=1. Fifth toggle -> overrun=1, dma_ptr=0x15. Raise mem_slot -> four writes at 0x10..0x13 in order.
- MIST and UIO toggles in the same cycle (dma_ptr=0x20, uio_addr=0x7F0000) -> writes issued at 0x20 then 0x7F0000; dma_ptr=0x21.
- dma_ptr=0x7FFFFF, rd_strobe toggle -> read at 0x7FFFFF; dma_ptr wraps to 0x000000.
- A rd_strobe toggle and a pending FIFO write both become ready at the same mem_slot -> READ is issued first, then WRITE after one IDLE cycle. mem_req stays stable over a 5-cycle-delayed mem_ack.
- Assert reset while mem_req=1 -> all outputs return to reset values immediately; after release, no transaction starts without a new event.
